// File: rtl/ts_hub_pkg.sv
// ---------------------------------------------------------------------------
// ts_hub_pkg
// Shared constants for the PTP timestamp capture hub: register byte
// addresses, STAT field positions and the width helpers used to size the
// per-channel FIFO entries and level counters.
// No ports (package).
// ---------------------------------------------------------------------------
package ts_hub_pkg;

  // Register byte addresses
  localparam logic [7:0] ADDR_CH_EN      = 8'h00;
  localparam logic [7:0] ADDR_SEL        = 8'h04;
  localparam logic [7:0] ADDR_STAT       = 8'h08;
  localparam logic [7:0] ADDR_POP        = 8'h0C;
  localparam logic [7:0] ADDR_HOLD_SEC_H = 8'h10;
  localparam logic [7:0] ADDR_HOLD_SEC_L = 8'h14;
  localparam logic [7:0] ADDR_HOLD_NS    = 8'h18;
  localparam logic [7:0] ADDR_HOLD_TAG   = 8'h1C;
  localparam logic [7:0] ADDR_IRQ_MASK   = 8'h20;
  localparam logic [7:0] ADDR_IRQ_STAT   = 8'h24;
  localparam logic [7:0] ADDR_DROP_CNT   = 8'h28;

  // STAT register layout
  localparam int STAT_LEVEL_W   = 7;
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 10;

  // Entry = {tag, sec[47:0], ns[31:0]}
  localparam int NS_W  = 32;
  localparam int SEC_W = 48;

  function automatic int entry_w(input int tag_w);
    return tag_w + SEC_W + NS_W;
  endfunction

  // One extra bit so a full FIFO (level == DEPTH) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ts_hub_fifo.sv
// ---------------------------------------------------------------------------
// ts_hub_fifo
// Synchronous first-word-fall-through FIFO for one capture channel.
// A push while full is accepted only if a pop happens in the same cycle, so
// a simultaneous push and pop on a full FIFO keeps level at DEPTH.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, din       write request and entry data
//   pop             read request (ignored while empty)
//   dout            head entry (valid while !empty)
//   level           number of stored entries, 0..DEPTH
//   empty, full     status flags derived from level
// ---------------------------------------------------------------------------
module ts_hub_fifo
  import ts_hub_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8,
  localparam int LW   = level_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; level/pointers decide what is valid,
  // so resetting the array would only cost flops and slow the write path.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ptp_ts_hub.sv
// ---------------------------------------------------------------------------
// ptp_ts_hub
// Multi-channel PTP timestamp capture hub. A rising edge on an enabled
// cap_in bit stores {tag, sec, ns} into that channel's FIFO; software
// selects a channel, pops entries into holding registers and reads them
// over the 8-bit-address / 32-bit-data register bus.
// Optional feature: define TS_HUB_DROP_CNT_EN to add per-channel 8-bit
// saturating drop counters at 0x28 (otherwise 0x28 reads 0).
// Ports:
//   clk, rst          RTC-domain clock, synchronous active-high reset
//   wr_in, rd_in      one-cycle register write / read strobes
//   addr_in, data_in  byte address and write data
//   data_out          registered read data, held until the next read
//   rtc_time_ptp_ns   current PTP nanoseconds
//   rtc_time_ptp_sec  current PTP seconds
//   cap_in            per-channel capture strobes (rising-edge sensitive)
//   cap_tag_in        per-channel tags, channel c at [c*TAG_W +: TAG_W]
//   irq_out           registered level interrupt, |(CH_EN & ~empty & MASK)
// ---------------------------------------------------------------------------
module ptp_ts_hub
  import ts_hub_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_in,
  input  logic                    rd_in,
  input  logic [7:0]              addr_in,
  input  logic [31:0]             data_in,
  output logic [31:0]             data_out,
  input  logic [31:0]             rtc_time_ptp_ns,
  input  logic [47:0]             rtc_time_ptp_sec,
  input  logic [NUM_CH-1:0]       cap_in,
  input  logic [NUM_CH*TAG_W-1:0] cap_tag_in,
  output logic                    irq_out
);

  localparam int EW = entry_w(TAG_W);
  localparam int LW = level_w(DEPTH);

  // Software-visible state
  logic [NUM_CH-1:0] ch_en;
  logic [3:0]        sel;
  logic [NUM_CH-1:0] irq_mask;
  logic [NUM_CH-1:0] ovf;
  logic [SEC_W-1:0]  hold_sec;
  logic [NS_W-1:0]   hold_ns;
  logic [TAG_W-1:0]  hold_tag;

  // Capture path
  logic [NUM_CH-1:0] cap_prev;
  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] pop_vec;
  logic [NUM_CH-1:0] ovf_clr;

  // FIFO outputs
  logic [EW-1:0]     fifo_dout  [NUM_CH];
  logic [LW-1:0]     fifo_level [NUM_CH];
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full;

  // Selected-channel view
  logic              sel_ok;
  logic [EW-1:0]     sel_dout;
  logic [LW-1:0]     sel_level;
  logic              sel_empty;
  logic              sel_full;
  logic              sel_ovf;

  // Register decode
  logic              wr_ch_en;
  logic              wr_sel;
  logic              wr_stat;
  logic              wr_irq_mask;
  logic              pop_req;
  logic [31:0]       rdata;

  assign sel_ok      = (int'(sel) < NUM_CH);
  assign wr_ch_en    = wr_in && (addr_in == ADDR_CH_EN);
  assign wr_sel      = wr_in && (addr_in == ADDR_SEL);
  assign wr_stat     = wr_in && (addr_in == ADDR_STAT);
  assign wr_irq_mask = wr_in && (addr_in == ADDR_IRQ_MASK);
  assign pop_req     = wr_in && (addr_in == ADDR_POP) && sel_ok;

  // -------------------------------------------------------------------------
  // Per-channel edge detect and FIFO
  // -------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // The reset term keeps a strobe edge during reset from being stored.
    assign fire[c] = cap_in[c] & ~cap_prev[c] & ch_en[c] & ~rst;
    // A capture on a full FIFO only survives if the same cycle pops it.
    assign drop[c] = fire[c] & fifo_full[c] & ~pop_vec[c];

    ts_hub_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fire[c]),
      .din   ({cap_tag_in[c*TAG_W +: TAG_W], rtc_time_ptp_sec, rtc_time_ptp_ns}),
      .pop   (pop_vec[c]),
      .dout  (fifo_dout[c]),
      .level (fifo_level[c]),
      .empty (fifo_empty[c]),
      .full  (fifo_full[c])
    );
  end

  // Selected-channel mux. A SEL beyond NUM_CH matches no channel, so
  // every field stays at its default and no POP or clear is routed.
  // NOTE: every output of this block gets a default first, so no path
  // through it leaves a value unassigned and no latch is inferred.
  always_comb begin
    sel_dout  = '0;
    sel_level = '0;
    sel_empty = 1'b0;
    sel_full  = 1'b0;
    sel_ovf   = 1'b0;
    pop_vec   = '0;
    ovf_clr   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel == 4'(c)) begin
        sel_dout   = fifo_dout[c];
        sel_level  = fifo_level[c];
        sel_empty  = fifo_empty[c];
        sel_full   = fifo_full[c];
        sel_ovf    = ovf[c];
        pop_vec[c] = pop_req;
        ovf_clr[c] = wr_stat & data_in[STAT_OVF_BIT];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional drop counters
  // -------------------------------------------------------------------------
`ifdef TS_HUB_DROP_CNT_EN
  logic [7:0] drop_cnt [NUM_CH];
  logic [7:0] sel_drop;
  logic       drop_clr;

  assign drop_clr = wr_in && (addr_in == ADDR_DROP_CNT) && sel_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) drop_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (drop_clr && (sel == 4'(c))) begin
          drop_cnt[c] <= '0;
        end else if (drop[c] && (drop_cnt[c] != 8'hFF)) begin
          drop_cnt[c] <= drop_cnt[c] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    sel_drop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel == 4'(c)) sel_drop = drop_cnt[c];
    end
  end
`else
  // Without counters the bus bits above the used fields have no consumer.
  logic unused_data_in;
  assign unused_data_in = ^data_in;
`endif

  // -------------------------------------------------------------------------
  // Read mux (pre-write state, so a same-cycle write is not visible)
  // -------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    case (addr_in)
      ADDR_CH_EN:    rdata = 32'(ch_en);
      ADDR_SEL:      rdata = 32'(sel);
      ADDR_STAT: begin
        if (sel_ok) begin
          rdata[STAT_LEVEL_W-1:0] = STAT_LEVEL_W'(sel_level);
          rdata[STAT_EMPTY_BIT]   = sel_empty;
          rdata[STAT_FULL_BIT]    = sel_full;
          rdata[STAT_OVF_BIT]     = sel_ovf;
        end
      end
      ADDR_HOLD_SEC_H: if (sel_ok) rdata = {16'b0, hold_sec[47:32]};
      ADDR_HOLD_SEC_L: if (sel_ok) rdata = hold_sec[31:0];
      ADDR_HOLD_NS:    if (sel_ok) rdata = hold_ns;
      ADDR_HOLD_TAG:   if (sel_ok) rdata = 32'(hold_tag);
      ADDR_IRQ_MASK: rdata = 32'(irq_mask);
      ADDR_IRQ_STAT: rdata = 32'(ch_en & ~fifo_empty & irq_mask);
      ADDR_DROP_CNT: begin
`ifdef TS_HUB_DROP_CNT_EN
        if (sel_ok) rdata = {24'b0, sel_drop};
`endif
      end
      default:       rdata = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control and status registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_prev <= '0;
      ch_en    <= '0;
      sel      <= '0;
      irq_mask <= '0;
      ovf      <= '0;
      hold_sec <= '0;
      hold_ns  <= '0;
      hold_tag <= '0;
      irq_out  <= 1'b0;
      data_out <= '0;
    end else begin
      cap_prev <= cap_in;
      if (wr_ch_en)    ch_en    <= data_in[NUM_CH-1:0];
      if (wr_sel)      sel      <= data_in[3:0];
      if (wr_irq_mask) irq_mask <= data_in[NUM_CH-1:0];

      // A new drop in the same cycle as a clear leaves the flag set.
      ovf <= (ovf & ~ovf_clr) | drop;

      if (pop_req && !sel_empty) begin
        hold_ns  <= sel_dout[NS_W-1:0];
        hold_sec <= sel_dout[NS_W +: SEC_W];
        hold_tag <= sel_dout[EW-1 -: TAG_W];
      end

      irq_out <= |(ch_en & ~fifo_empty & irq_mask);

      if (rd_in) data_out <= rdata;
    end
  end

endmodule

// File: tb/tb_ptp_ts_hub.sv
// ---------------------------------------------------------------------------
// tb_ptp_ts_hub
// Directed self-checking bench for ptp_ts_hub with NUM_CH=4, DEPTH=8,
// TAG_W=16. Inputs change on the falling edge; outputs are sampled on the
// falling edge, half a cycle after the active edge.
// ---------------------------------------------------------------------------
module tb_ptp_ts_hub;
  import ts_hub_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int TAG_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    wr_in = 1'b0;
  logic                    rd_in = 1'b0;
  logic [7:0]              addr_in = '0;
  logic [31:0]             data_in = '0;
  logic [31:0]             data_out;
  logic [31:0]             rtc_time_ptp_ns = '0;
  logic [47:0]             rtc_time_ptp_sec = '0;
  logic [NUM_CH-1:0]       cap_in = '0;
  logic [NUM_CH*TAG_W-1:0] cap_tag_in = '0;
  logic                    irq_out;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] rd;
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  ptp_ts_hub #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_in            (wr_in),
    .rd_in            (rd_in),
    .addr_in          (addr_in),
    .data_in          (data_in),
    .data_out         (data_out),
    .rtc_time_ptp_ns  (rtc_time_ptp_ns),
    .rtc_time_ptp_sec (rtc_time_ptp_sec),
    .cap_in           (cap_in),
    .cap_tag_in       (cap_tag_in),
    .irq_out          (irq_out)
  );

  // All helpers start and end just after a falling edge.
  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    wr_in = 1'b1; addr_in = a; data_in = d;
    @(negedge clk);
    wr_in = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
    rd_in = 1'b1; addr_in = a;
    @(negedge clk);
    rd_in = 1'b0;
    d = data_out;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] m);
    cap_in = m;
    @(negedge clk);
    cap_in = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h want %h", data_out, 32'h0); end
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_out); end
    reg_rd(ADDR_CH_EN, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ch_en: got %h want %h", rd, 32'h0); end
    reg_rd(ADDR_STAT, rd);
    checks++; if (rd !== 32'h100) begin errors++; $display("FAIL reset_stat: got %h want %h", rd, 32'h100); end
    reg_rd(ADDR_HOLD_NS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_hold_ns: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_basic_capture();
    reg_wr(ADDR_CH_EN, 32'h1);
    reg_wr(ADDR_SEL, 32'h0);
    cap_tag_in       = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h00AB};
    rtc_time_ptp_sec = 48'h0000_0000_0005;
    rtc_time_ptp_ns  = 32'h3B9A_C9FF;
    pulse(4'b0001);
    reg_rd(ADDR_STAT, rd);
    checks++; if (rd !== 32'h001) begin errors++; $display("FAIL basic_level: got %h want %h", rd, 32'h001); end
    rtc_time_ptp_ns = 32'h1234_5678;  // must not leak into the stored entry
    reg_wr(ADDR_POP, 32'h0);
    reg_rd(ADDR_HOLD_SEC_H, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL basic_sec_h: got %h want %h", rd, 32'h0); end
    reg_rd(ADDR_HOLD_SEC_L, rd);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL basic_sec_l: got %h want %h", rd, 32'h5); end
    reg_rd(ADDR_HOLD_NS, rd);
    checks++; if (rd !== 32'h3B9A_C9FF) begin errors++; $display("FAIL basic_ns: got %h want %h", rd, 32'h3B9AC9FF); end
    reg_rd(ADDR_HOLD_TAG, rd);
    checks++; if (rd !== 32'h0000_00AB) begin errors++; $display("FAIL basic_tag: got %h want %h", rd, 32'hAB); end
    reg_rd(ADDR_STAT, rd);
    checks++; if (rd !== 32'h100) begin errors++; $display("FAIL basic_empty_after_pop: got %h want %h", rd, 32'h100); end
  endtask

  task automatic test_edge_only();
    reg_wr(ADDR_CH_EN, 32'h2);
    cap_in = 4'b0010;
    repeat (10) @(negedge clk);
    cap_in = '0;
    @(negedge clk);
    reg_wr(ADDR_SEL, 32'h1);
    reg_rd(ADDR_STAT, rd);
    checks++; if (rd !== 32'h001) begin errors++; $display("FAIL held_strobe_level: got %h want %h", rd, 32'h001); end
    pulse(4'b0100);
    reg_wr(ADDR_SEL, 32'h2);
    reg_rd(ADDR_STAT, rd);
    checks++; if (rd !== 32'h100) begin errors++; $display("FAIL disabled_ch_stat: got %h want %h", rd, 32'h100); end
    reg_wr(ADDR_SEL, 32'h1);
    reg_wr(ADDR_POP, 32'h0);
  endtask

  task automatic test_overflow();
    reg_wr(ADDR_CH_EN, 32'h1);
    reg_wr(ADDR_SEL, 32'h0);
    for (int i = 0; i < 10; i++) begin
      rtc_time_ptp_ns = 32'(i);
      pulse(4'b0001);
    end
    reg_rd(ADDR_STAT, rd);
    checks++; if (rd !== 32'h608) begin errors++; $display("FAIL overflow_stat: got %h want %h", rd, 32'h608); end
`ifdef TS_HUB_DROP_CNT_EN
    exp_v = 32'd2;
`else
    exp_v = 32'd0;
`endif
    reg_rd(ADDR_DROP_CNT, rd);
    checks++; if (rd !== exp_v) begin errors++; $display("FAIL drop_cnt: got %h want %h", rd, exp_v); end
    reg_wr(ADDR_STAT, 32'h400);
    reg_rd(ADDR_STAT, rd);
    checks++; if (rd !== 32'h208) begin errors++; $display("FAIL overflow_clear: got %h want %h", rd, 32'h208); end
  endtask

  // Channel 0 is full with ns = 0..7 on entry.
  task automatic test_pop_and_capture_full();
    wr_in = 1'b1; addr_in = ADDR_POP; data_in = '0;
    rtc_time_ptp_ns = 32'd100;
    cap_in = 4'b0001;
    @(negedge clk);
    wr_in = 1'b0; cap_in = '0;
    @(negedge clk);
    reg_rd(ADDR_STAT, rd);
    checks++; if (rd !== 32'h208) begin errors++; $display("FAIL popcap_stat: got %h want %h", rd, 32'h208); end
    reg_rd(ADDR_HOLD_NS, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL popcap_oldest: got %h want %h", rd, 32'd0); end
    repeat (7) reg_wr(ADDR_POP, 32'h0);
    reg_rd(ADDR_HOLD_NS, rd);
    checks++; if (rd !== 32'd7) begin errors++; $display("FAIL popcap_seventh: got %h want %h", rd, 32'd7); end
    reg_wr(ADDR_POP, 32'h0);
    reg_rd(ADDR_HOLD_NS, rd);
    checks++; if (rd !== 32'd100) begin errors++; $display("FAIL popcap_tail: got %h want %h", rd, 32'd100); end
    reg_rd(ADDR_STAT, rd);
    checks++; if (rd !== 32'h100) begin errors++; $display("FAIL popcap_drained: got %h want %h", rd, 32'h100); end
    reg_wr(ADDR_POP, 32'h0);  // pop on empty must leave holding untouched
    reg_rd(ADDR_HOLD_NS, rd);
    checks++; if (rd !== 32'd100) begin errors++; $display("FAIL pop_empty_hold: got %h want %h", rd, 32'd100); end
  endtask

  task automatic test_irq();
    reg_wr(ADDR_CH_EN, 32'h8);
    reg_wr(ADDR_IRQ_MASK, 32'h8);
    cap_in = 4'b1000;
    @(negedge clk);
    cap_in = '0;
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_t1: got %b want 0", irq_out); end
    @(negedge clk);
    checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_t2: got %b want 1", irq_out); end
    reg_rd(ADDR_IRQ_STAT, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL irq_stat: got %h want %h", rd, 32'h8); end
    reg_wr(ADDR_SEL, 32'h3);
    reg_wr(ADDR_POP, 32'h0);
    @(negedge clk);
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_after_pop: got %b want 0", irq_out); end
  endtask

  task automatic test_wr_rd_same_cycle();
    wr_in = 1'b1; rd_in = 1'b1; addr_in = ADDR_CH_EN; data_in = 32'h3;
    @(negedge clk);
    wr_in = 1'b0; rd_in = 1'b0;
    checks++; if (data_out !== 32'h8) begin errors++; $display("FAIL wr_rd_pre_write: got %h want %h", data_out, 32'h8); end
    reg_rd(ADDR_CH_EN, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL wr_rd_post_write: got %h want %h", rd, 32'h3); end
  endtask

  task automatic test_sel_range();
    reg_wr(ADDR_SEL, 32'h5);
    reg_rd(ADDR_STAT, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sel_oob_stat: got %h want %h", rd, 32'h0); end
    reg_rd(ADDR_HOLD_SEC_L, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sel_oob_hold: got %h want %h", rd, 32'h0); end
    reg_rd(8'h30, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_reset_mid();
    reg_wr(ADDR_CH_EN, 32'hF);
    reg_wr(ADDR_IRQ_MASK, 32'hF);
    pulse(4'b1111);
    @(negedge clk);
    checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", irq_out); end
    reg_rd(ADDR_CH_EN, rd);
    rst = 1'b1;
    cap_in = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    cap_in = '0;
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data_out: got %h want %h", data_out, 32'h0); end
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq_out); end
    for (int c = 0; c < NUM_CH; c++) begin
      reg_wr(ADDR_SEL, 32'(c));
      reg_rd(ADDR_STAT, rd);
      checks++; if (rd !== 32'h100) begin errors++; $display("FAIL rst_flush_ch%0d: got %h want %h", c, rd, 32'h100); end
    end
    reg_rd(ADDR_HOLD_NS, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_hold_ns: got %h want %h", rd, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_edge_only();
    test_overflow();
    test_pop_and_capture_full();
    test_irq();
    test_wr_rd_same_cycle();
    test_sel_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
